elixirchip_es1_spu_op_mac: RTL and testbench

//  Pipelined multiply-accumulate SPU op; successor to the plain multiplier op.

---
 rtl/elixirchip_es1_spu_pkg.sv | 41 ++++
 rtl/elixirchip_es1_spu_op_mac_delay.sv | 51 +++++
 rtl/elixirchip_es1_spu_op_mac.sv | 190 +++++++++++++++++++
 tb/tb_elixirchip_es1_spu_op_mac.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared definitions for the ES1 SPU op blocks.
//  MAC_MIN_LATENCY : shortest legal s_* -> m_* latency of the MAC op
//                    (input reg, multiply, accumulate, narrow).
//  SAT_MAX_BITS    : widest value sat_narrow can clamp.
//  sat_narrow()    : clamps a value to the range of an out_bits-wide
//                    signed or unsigned number. The caller must sign- or
//                    zero-extend the value to 64 bits and keep the low
//                    out_bits of the result.
package elixirchip_es1_spu_pkg;

  localparam int MAC_MIN_LATENCY = 4;
  localparam int SAT_MAX_BITS    = 64;

  // out_bits must be in 1..63.
  function automatic logic [SAT_MAX_BITS-1:0] sat_narrow(
    input logic [SAT_MAX_BITS-1:0] value,
    input int                      out_bits,
    input bit                      is_signed
  );
    logic [SAT_MAX_BITS-1:0] hi;
    logic [SAT_MAX_BITS-1:0] lo;
    logic [SAT_MAX_BITS-1:0] result;
    result = value;
    if (is_signed) begin
      hi = (64'd1 << (out_bits - 1)) - 64'd1;
      lo = ~hi;  // -(2^(n-1)) in 64-bit two's complement
      if ($signed(value) > $signed(hi)) begin
        result = hi;
      end else if ($signed(value) < $signed(lo)) begin
        result = lo;
      end
    end else begin
      hi = (64'd1 << out_bits) - 64'd1;
      if (value > hi) begin
        result = hi;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_mac_delay.sv
// Clock-enabled delay line used for the tail of the MAC pipeline.
//  clk      : clock
//  reset    : asynchronous, active-low reset; clears every stage to 0
//  cke      : clock enable; 0 freezes every stage
//  in_data  : DATA_BITS-wide input
//  out_data : in_data delayed by DEPTH cke-qualified cycles
//             (DEPTH=0 is a pure wire)
module elixirchip_es1_spu_op_mac_delay #(
  parameter int DATA_BITS = 1,
  parameter int DEPTH     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic [DATA_BITS-1:0] in_data,
  output logic [DATA_BITS-1:0] out_data
);

  if (DEPTH < 0) begin : g_bad_depth
    $error("elixirchip_es1_spu_op_mac_delay: DEPTH must be >= 0");
  end

  if (DEPTH == 0) begin : g_wire
    assign out_data = in_data;

    // Clock, reset and enable have nothing to drive in the wire case.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, cke};
  end else begin : g_regs
    logic [DATA_BITS-1:0] stage [DEPTH];

    // NOTE: every stage is reset, not only the head. These carry m_valid,
    // so a stale 1 left in the line would leak a bogus output pulse after
    // reset; this is a short pipeline, not a RAM.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage[i] <= '0;
        end
      end else if (cke) begin
        stage[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign out_data = stage[DEPTH-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_mac.sv
// Pipelined multiply-accumulate SPU op.
//  clk      : clock
//  reset    : asynchronous, active-low reset (pipeline, acc, outputs -> 0)
//  cke      : clock enable; 0 freezes every register including acc
//  s_data0  : multiplicand
//  s_data1  : multiplier
//  s_clear  : 1 starts a new sum (acc <= product)
//  s_valid  : qualifies s_data0/s_data1/s_clear
//  m_data   : running sum, shifted right by DATA_SHIFT then narrowed
//             (saturated or truncated) to M_DATA_BITS
//  m_valid  : m_data was updated by a valid sample this cycle
// Pipeline: st0 input regs -> st1 product -> st2 accumulator ->
// st3 shift/narrow -> LATENCY-4 tail stages.
module elixirchip_es1_spu_op_mac
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int LATENCY      = 4,
  parameter int S_DATA0_BITS = 8,
  parameter int S_DATA1_BITS = 8,
  parameter int ACC_BITS     = 24,
  parameter int M_DATA_BITS  = 16,
  parameter int DATA_SHIFT   = 0,
  parameter bit SIGNED       = 1'b0,
  parameter bit SATURATE     = 1'b0,
  parameter     DEVICE       = "RTL",
  parameter     SIMULATION   = "false",
  parameter     DEBUG        = "false"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cke,
  input  logic [S_DATA0_BITS-1:0] s_data0,
  input  logic [S_DATA1_BITS-1:0] s_data1,
  input  logic                    s_clear,
  input  logic                    s_valid,
  output logic [M_DATA_BITS-1:0]  m_data,
  output logic                    m_valid
);

  // ---------------------------------------------------------------- checks
  if (LATENCY < MAC_MIN_LATENCY) begin : g_bad_latency
    $error("elixirchip_es1_spu_op_mac: LATENCY must be >= %0d", MAC_MIN_LATENCY);
  end
  if (ACC_BITS < S_DATA0_BITS + S_DATA1_BITS) begin : g_bad_acc
    $error("elixirchip_es1_spu_op_mac: ACC_BITS must be >= S_DATA0_BITS+S_DATA1_BITS");
  end
  if (ACC_BITS > SAT_MAX_BITS || M_DATA_BITS >= SAT_MAX_BITS) begin : g_bad_width
    $error("elixirchip_es1_spu_op_mac: ACC_BITS <= 64 and M_DATA_BITS < 64 required");
  end
  if (DATA_SHIFT < 0 || DATA_SHIFT >= ACC_BITS) begin : g_bad_shift
    $error("elixirchip_es1_spu_op_mac: DATA_SHIFT must be in 0..ACC_BITS-1");
  end
  if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_sim
    $error("elixirchip_es1_spu_op_mac: SIMULATION must be \"true\" or \"false\"");
  end
  if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
    $error("elixirchip_es1_spu_op_mac: DEBUG must be \"true\" or \"false\"");
  end
  if (DEVICE == "") begin : g_bad_device
    $error("elixirchip_es1_spu_op_mac: DEVICE must not be empty");
  end

  // ------------------------------------------------------------ registers
  logic [S_DATA0_BITS-1:0] st0_data0;
  logic [S_DATA1_BITS-1:0] st0_data1;
  logic                    st0_clear;
  logic                    st0_valid;

  logic [ACC_BITS-1:0]     st1_prod;
  logic                    st1_clear;
  logic                    st1_valid;

  logic [ACC_BITS-1:0]     acc;
  logic                    st2_valid;

  logic [M_DATA_BITS-1:0]  st3_data;
  logic                    st3_valid;

  // ------------------------------------------------------- combinational
  logic [ACC_BITS-1:0]     ext0;
  logic [ACC_BITS-1:0]     ext1;
  logic [ACC_BITS-1:0]     prod;
  logic [ACC_BITS-1:0]     sh;
  logic [SAT_MAX_BITS-1:0] sh_wide;
  logic [SAT_MAX_BITS-1:0] sat_wide;
  logic [M_DATA_BITS-1:0]  narrowed;

  // Operands are extended to the accumulator width before multiplying, so
  // the low ACC_BITS of the product are correct for both signednesses.
  always_comb begin
    // NOTE: every variable gets a value on every path through this block;
    // a path that skipped one would make synthesis infer a latch.
    ext0 = '0;
    ext1 = '0;
    if (SIGNED) begin
      ext0 = {{(ACC_BITS - S_DATA0_BITS){st0_data0[S_DATA0_BITS-1]}}, st0_data0};
      ext1 = {{(ACC_BITS - S_DATA1_BITS){st0_data1[S_DATA1_BITS-1]}}, st0_data1};
    end else begin
      ext0 = {{(ACC_BITS - S_DATA0_BITS){1'b0}}, st0_data0};
      ext1 = {{(ACC_BITS - S_DATA1_BITS){1'b0}}, st0_data1};
    end
    prod = ext0 * ext1;
  end

  // Shift and narrow. The two shift flavours live in separate branches: in
  // a single ?: the unsigned arm would make the whole expression unsigned
  // and silently turn >>> into a logical shift.
  always_comb begin
    sh      = '0;
    sh_wide = '0;
    if (SIGNED) begin
      sh      = $signed(acc) >>> DATA_SHIFT;
      sh_wide = 64'($signed(sh));
    end else begin
      sh      = acc >> DATA_SHIFT;
      sh_wide = 64'(sh);
    end
    sat_wide = sat_narrow(sh_wide, M_DATA_BITS, SIGNED);
    if (SATURATE) begin
      narrowed = sat_wide[M_DATA_BITS-1:0];
    end else begin
      narrowed = sh_wide[M_DATA_BITS-1:0];
    end
  end

  // Only the low M_DATA_BITS of the clamp result are kept.
  logic unused_sat;
  assign unused_sat = ^sat_wide;

  // ------------------------------------------------------------- pipeline
  // NOTE: state is written with non-blocking assignments so every stage
  // reads its predecessor's value from before this edge; blocking writes
  // here would collapse stages and make behaviour depend on statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st0_data0 <= '0;
      st0_data1 <= '0;
      st0_clear <= 1'b0;
      st0_valid <= 1'b0;
      st1_prod  <= '0;
      st1_clear <= 1'b0;
      st1_valid <= 1'b0;
      acc       <= '0;
      st2_valid <= 1'b0;
      st3_data  <= '0;
      st3_valid <= 1'b0;
    end else if (cke) begin
      // st0: capture operands
      st0_data0 <= s_data0;
      st0_data1 <= s_data1;
      st0_clear <= s_clear;
      st0_valid <= s_valid;
      // st1: product
      st1_prod  <= prod;
      st1_clear <= st0_clear;
      st1_valid <= st0_valid;
      // st2: accumulate; wraps modulo 2^ACC_BITS, bubbles leave acc alone
      if (st1_valid) begin
        acc <= st1_clear ? st1_prod : acc + st1_prod;
      end
      st2_valid <= st1_valid;
      // st3: narrowed output holds across bubbles
      if (st2_valid) begin
        st3_data <= narrowed;
      end
      st3_valid <= st2_valid;
    end
  end

  // ----------------------------------------------------------------- tail
  logic [M_DATA_BITS:0] tail_in;
  logic [M_DATA_BITS:0] tail_out;

  assign tail_in = {st3_valid, st3_data};

  elixirchip_es1_spu_op_mac_delay #(
    .DATA_BITS (M_DATA_BITS + 1),
    .DEPTH     (LATENCY - MAC_MIN_LATENCY)
  ) u_tail (
    .clk      (clk),
    .reset    (reset),
    .cke      (cke),
    .in_data  (tail_in),
    .out_data (tail_out)
  );

  assign m_valid = tail_out[M_DATA_BITS];
  assign m_data  = tail_out[M_DATA_BITS-1:0];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_mac.sv
// Bench for elixirchip_es1_spu_op_mac. Four instances share one stimulus
// stream:
//  0: defaults (unsigned, truncate, LATENCY 4)
//  1: SATURATE=1
//  2: SIGNED=1, SATURATE=1, DATA_SHIFT=2
//  3: LATENCY=7
// The model keeps the mathematical running sum per instance and records the
// expected output for every accepted clock; a compare process checks each
// instance on every falling edge against the entry LATENCY accepted clocks
// back.
module tb_elixirchip_es1_spu_op_mac;

  localparam int NCFG = 4;
  localparam int LAT  [NCFG] = '{4, 4, 4, 7};
  localparam bit SGN  [NCFG] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam bit SAT  [NCFG] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam int SHF  [NCFG] = '{0, 0, 2, 0};

  logic        clk;
  logic        reset;
  logic        cke;
  logic [7:0]  s_data0;
  logic [7:0]  s_data1;
  logic        s_clear;
  logic        s_valid;
  logic [15:0] md [NCFG];
  logic        mv [NCFG];

  int n_checks = 0;
  int n_pass   = 0;

  // ------------------------------------------------------------------ DUTs
  elixirchip_es1_spu_op_mac u_dut0 (
    .clk(clk), .reset(reset), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(md[0]), .m_valid(mv[0]));

  elixirchip_es1_spu_op_mac #(.SATURATE(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(md[1]), .m_valid(mv[1]));

  elixirchip_es1_spu_op_mac #(.SIGNED(1'b1), .SATURATE(1'b1), .DATA_SHIFT(2)) u_dut2 (
    .clk(clk), .reset(reset), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(md[2]), .m_valid(mv[2]));

  elixirchip_es1_spu_op_mac #(.LATENCY(7)) u_dut3 (
    .clk(clk), .reset(reset), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(md[3]), .m_valid(mv[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ----------------------------------------------------------------- model
  typedef struct packed {
    logic [NCFG-1:0][15:0] d;
    logic                  v;
  } entry_t;

  entry_t      hist[$];       // one entry per accepted clock since reset
  longint      accm [NCFG];   // true accumulator value per instance
  logic [15:0] curd [NCFG];   // current (held) narrowed output

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int c = 0; c < NCFG; c++) begin
      accm[c] = 0;
      curd[c] = '0;
    end
  endtask

  task automatic model_push(input bit v, input logic [7:0] a, input logic [7:0] b, input bit clr);
    entry_t e;
    if (v) begin
      for (int c = 0; c < NCFG; c++) begin
        longint x, y, s;
        x = SGN[c] ? longint'($signed(a)) : longint'(a);
        y = SGN[c] ? longint'($signed(b)) : longint'(b);
        s = (clr ? 0 : accm[c]) + x * y;
        s = s & 64'hFF_FFFF;                          // 24-bit accumulator wraps
        if (SGN[c] && s >= 64'h80_0000) s = s - 64'h100_0000;
        accm[c] = s;
        s = s >>> SHF[c];
        if (SAT[c]) begin
          if (SGN[c]) begin
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
          end else if (s > 65535) begin
            s = 65535;
          end
        end
        curd[c] = s[15:0];
      end
    end
    for (int c = 0; c < NCFG; c++) e.d[c] = curd[c];
    e.v = v;
    hist.push_back(e);
  endtask

  // Checks the most recent model entry of one instance against a hand value.
  task automatic pin(input string name, input int c, input logic [15:0] expected);
    check(name, hist[$].d[c], expected);
  endtask

  // ------------------------------------------------------------- compare
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) begin
        int          idx;
        logic [15:0] ed;
        logic        ev;
        idx = hist.size() - LAT[c];
        ed  = '0;
        ev  = 1'b0;
        if (idx >= 0) begin
          ed = hist[idx].d[c];
          ev = hist[idx].v;
        end
        check($sformatf("dut%0d m_data", c), md[c], ed);
        check($sformatf("dut%0d m_valid", c), mv[c], ev);
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input bit clr, input bit ce);
    s_valid = v;
    s_data0 = a;
    s_data1 = b;
    s_clear = clr;
    cke     = ce;
    @(posedge clk);
    if (reset && ce) model_push(v, a, b, clr);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
  endtask

  initial begin
    reset   = 1'b1;
    cke     = 1'b1;
    s_data0 = '0;
    s_data1 = '0;
    s_clear = 1'b0;
    s_valid = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("reset dut%0d m_data", c), md[c], 0);
      check($sformatf("reset dut%0d m_valid", c), mv[c], 0);
    end
    reset = 1'b1;

    // Basic sum
    step(1'b1, 8'd3, 8'd4, 1'b1, 1'b1); pin("sum 12", 0, 16'd12);
    step(1'b1, 8'd5, 8'd6, 1'b0, 1'b1); pin("sum 42", 0, 16'd42);
    step(1'b1, 8'd7, 8'd8, 1'b0, 1'b1); pin("sum 98", 0, 16'd98);
    pin("sum 98 lat7", 3, 16'd98);
    idle(8);

    // Narrowing: truncate vs saturate
    step(1'b1, 8'd255, 8'd255, 1'b1, 1'b1);
    pin("trunc 65025", 0, 16'd65025);
    pin("sat 65025", 1, 16'd65025);
    step(1'b1, 8'd255, 8'd255, 1'b0, 1'b1);
    pin("trunc 64514", 0, 16'd64514);
    pin("sat 65535", 1, 16'd65535);
    idle(6);

    // Signed with shift and saturate
    step(1'b1, 8'hFD, 8'd4, 1'b1, 1'b1);
    pin("signed -3", 2, 16'hFFFD);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h80, 8'h7F, 1'b0, 1'b1);
    pin("signed -16259", 2, 16'hC07D);
    idle(6);

    // Gaps, an ignored clear on an invalid slot, and a 3-cycle stall
    step(1'b1, 8'd1, 8'd2, 1'b1, 1'b1); pin("gap 2", 0, 16'd2);
    step(1'b0, 8'd9, 8'd9, 1'b1, 1'b1); pin("gap hold", 0, 16'd2);
    step(1'b1, 8'd3, 8'd3, 1'b0, 1'b1); pin("gap 11", 0, 16'd11);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd9, 8'd9, 1'b0, 1'b0);
    step(1'b1, 8'd2, 8'd5, 1'b0, 1'b1); pin("stall 21", 0, 16'd21);
    step(1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    idle(8);

    // Reset mid-stream: in-flight samples vanish at once
    step(1'b1, 8'd2, 8'd3, 1'b1, 1'b1);
    step(1'b1, 8'd4, 8'd4, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("async reset dut%0d m_data", c), md[c], 0);
      check($sformatf("async reset dut%0d m_valid", c), mv[c], 0);
    end
    model_reset();
    step(1'b1, 8'd5, 8'd5, 1'b1, 1'b1);
    step(1'b1, 8'd5, 8'd5, 1'b1, 1'b1);
    reset = 1'b1;
    step(1'b1, 8'd2, 8'd2, 1'b0, 1'b1); pin("after reset 4", 0, 16'd4);
    idle(8);

    // Clear every cycle: constant output
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'd1, 8'd1, 1'b1, 1'b1);
      pin("const 1 lat7", 3, 16'd1);
    end
    idle(8);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0);
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
